// File: rtl/parity_tx_ctrl.sv
// Byte-framing serial transmitter: start, 8 data bits LSB first, parity, stop bit(s).
// Optional PARITY_TX_ERRINJ_EN adds inject_err to invert the parity bit of one frame.
module parity_tx_ctrl #(
  parameter int EVENP        = 1,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
`ifdef PARITY_TX_ERRINJ_EN
  ,
  input  logic       inject_err
`endif
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       data_q;
  logic             par_q;
  logic             tx_q;
  logic             done_q;
  logic             inj;
  logic             bit_end;

  function automatic logic parity_bit(input logic [7:0] b);
    return (EVENP != 0) ? ^b : ~^b;
  endfunction

`ifdef PARITY_TX_ERRINJ_EN
  assign inj = inject_err;
`else
  assign inj = 1'b0;
`endif

  assign bit_end = (clk_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          tx_q    <= 1'b1;
          clk_cnt <= '0;
          bit_idx <= '0;
          // ready is high whenever IDLE and out of reset, so valid alone is the handshake
          if (valid) begin
            data_q <= data_in;
            par_q  <= parity_bit(data_in) ^ inj;
            tx_q   <= 1'b0;
            state  <= START;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            tx_q    <= data_q[0];
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_q  <= par_q;
              state <= PARITY;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= data_q[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            tx_q    <= 1'b1;
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          // bit_idx counts stop bits here
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              done_q  <= 1'b1;
              state   <= IDLE;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready = (state == IDLE) && !rst;
  assign busy  = (state != IDLE);
  assign tx    = tx_q;
  assign done  = done_q;

endmodule

// File: tb/tb_parity_tx_ctrl.sv
// Directed bench for parity_tx_ctrl: three instances cover even/odd parity,
// single-clock bits, and 4-clock bits with two stop bits.
module tb_parity_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       inject_err;
  logic       valid_a, valid_b, valid_c;
  logic       ready_a, ready_b, ready_c;
  logic       tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  parity_tx_ctrl #(.EVENP(1), .CLKS_PER_BIT(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .valid(valid_a), .ready(ready_a),
    .tx(tx_a), .busy(busy_a), .done(done_a)
`ifdef PARITY_TX_ERRINJ_EN
    , .inject_err(inject_err)
`endif
  );

  parity_tx_ctrl #(.EVENP(0), .CLKS_PER_BIT(1), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_in), .valid(valid_b), .ready(ready_b),
    .tx(tx_b), .busy(busy_b), .done(done_b)
`ifdef PARITY_TX_ERRINJ_EN
    , .inject_err(inject_err)
`endif
  );

  parity_tx_ctrl #(.EVENP(1), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst(rst), .data_in(data_in), .valid(valid_c), .ready(ready_c),
    .tx(tx_c), .busy(busy_c), .done(done_c)
`ifdef PARITY_TX_ERRINJ_EN
    , .inject_err(inject_err)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic tx_s(input int s);
    case (s)
      0: return tx_a;
      1: return tx_b;
      default: return tx_c;
    endcase
  endfunction

  function automatic logic busy_s(input int s);
    case (s)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic ready_s(input int s);
    case (s)
      0: return ready_a;
      1: return ready_b;
      default: return ready_c;
    endcase
  endfunction

  function automatic logic done_s(input int s);
    case (s)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  // Send one byte on a single-clock-per-bit instance (sel 0 or 1) and check every frame cycle.
  task automatic test_frame(input int sel, input logic [7:0] b, input logic p, input string nm);
    logic [10:0] exp_bits;
    exp_bits = {1'b1, p, b, 1'b0};
    data_in = b;
    if (sel == 0) valid_a = 1'b1;
    else valid_b = 1'b1;
    total_cnt++;
    if (ready_s(sel) !== 1'b1 || busy_s(sel) !== 1'b0)
      $display("FAIL %s accept: ready=%b busy=%b, want ready=1 busy=0", nm, ready_s(sel), busy_s(sel));
    else pass_cnt++;
    tick();
    valid_a = 1'b0;
    valid_b = 1'b0;
    for (int i = 0; i < 11; i++) begin
      total_cnt++;
      if (tx_s(sel) !== exp_bits[i] || busy_s(sel) !== 1'b1 || ready_s(sel) !== 1'b0)
        $display("FAIL %s cycle %0d: tx=%b busy=%b ready=%b, want tx=%b busy=1 ready=0",
                 nm, i + 1, tx_s(sel), busy_s(sel), ready_s(sel), exp_bits[i]);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (done_s(sel) !== 1'b1 || busy_s(sel) !== 1'b0 || ready_s(sel) !== 1'b1 || tx_s(sel) !== 1'b1)
      $display("FAIL %s done cycle: done=%b busy=%b ready=%b tx=%b, want 1 0 1 1",
               nm, done_s(sel), busy_s(sel), ready_s(sel), tx_s(sel));
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done_s(sel) !== 1'b0)
      $display("FAIL %s done width: done=%b, want 0", nm, done_s(sel));
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_a = 1'b1;
    data_in = 8'hFF;
    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      total_cnt++;
      if (tx_s(s) !== 1'b1 || ready_s(s) !== 1'b0 || busy_s(s) !== 1'b0 || done_s(s) !== 1'b0)
        $display("FAIL reset dut%0d: tx=%b ready=%b busy=%b done=%b, want 1 0 0 0",
                 s, tx_s(s), ready_s(s), busy_s(s), done_s(s));
      else pass_cnt++;
    end
    rst = 1'b0;
    valid_a = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      total_cnt++;
      if (ready_s(s) !== 1'b1 || busy_s(s) !== 1'b0)
        $display("FAIL reset_release dut%0d: ready=%b busy=%b, want 1 0", s, ready_s(s), busy_s(s));
      else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_basic();
    test_frame(0, 8'hA5, 1'b0, "basic_a5");
  endtask

  task automatic test_parity();
    test_frame(0, 8'h07, 1'b1, "even_07");
    test_frame(0, 8'h00, 1'b0, "even_00");
    test_frame(1, 8'h07, 1'b0, "odd_07");
    test_frame(1, 8'h00, 1'b1, "odd_00");
  endtask

  task automatic test_stop2();
    logic e;
    data_in = 8'hFF;
    valid_c = 1'b1;
    total_cnt++;
    if (ready_c !== 1'b1)
      $display("FAIL stop2 accept: ready=%b, want 1", ready_c);
    else pass_cnt++;
    tick();
    valid_c = 1'b0;
    for (int i = 0; i < 48; i++) begin
      e = (i < 4) ? 1'b0 : (i < 36) ? 1'b1 : (i < 40) ? 1'b0 : 1'b1;
      total_cnt++;
      if (tx_c !== e || busy_c !== 1'b1 || done_c !== 1'b0)
        $display("FAIL stop2 cycle %0d: tx=%b busy=%b done=%b, want tx=%b busy=1 done=0",
                 i + 1, tx_c, busy_c, done_c, e);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (done_c !== 1'b1 || busy_c !== 1'b0 || tx_c !== 1'b1)
      $display("FAIL stop2 done: done=%b busy=%b tx=%b, want 1 0 1", done_c, busy_c, tx_c);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done_c !== 1'b0)
      $display("FAIL stop2 done width: done=%b, want 0", done_c);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [10:0] f1, f2;
    logic        e;
    int          ndone;
    f1 = {1'b1, 1'b0, 8'h3C, 1'b0};
    f2 = {1'b1, 1'b0, 8'hC3, 1'b0};
    ndone = 0;
    data_in = 8'h3C;
    valid_a = 1'b1;
    tick();
    data_in = 8'hC3;
    for (int i = 0; i < 25; i++) begin
      if (done_a === 1'b1) ndone++;
      if (i < 23) begin
        e = (i < 11) ? f1[i] : (i == 11) ? 1'b1 : f2[i - 12];
        total_cnt++;
        if (tx_a !== e)
          $display("FAIL b2b cycle %0d: tx=%b, want %b", i + 1, tx_a, e);
        else pass_cnt++;
      end
      if (i == 11) begin
        total_cnt++;
        if (done_a !== 1'b1 || ready_a !== 1'b1)
          $display("FAIL b2b gap: done=%b ready=%b, want 1 1", done_a, ready_a);
        else pass_cnt++;
      end
      if (i == 12) begin
        valid_a = 1'b0;
        data_in = 8'h00;
      end
      tick();
    end
    total_cnt++;
    if (ndone != 2)
      $display("FAIL b2b done count: got %0d, want 2", ndone);
    else pass_cnt++;
  endtask

  task automatic test_rst_mid();
    int ndone;
    ndone = 0;
    data_in = 8'h55;
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    repeat (4) tick();
    total_cnt++;
    if (tx_a !== 1'b0 || busy_a !== 1'b1)
      $display("FAIL rst_mid bit3: tx=%b busy=%b, want 0 1", tx_a, busy_a);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    total_cnt++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || ready_a !== 1'b0 || done_a !== 1'b0)
      $display("FAIL rst_mid after: tx=%b busy=%b ready=%b done=%b, want 1 0 0 0",
               tx_a, busy_a, ready_a, done_a);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (ready_a !== 1'b1)
      $display("FAIL rst_mid release: ready=%b, want 1", ready_a);
    else pass_cnt++;
    for (int i = 0; i < 12; i++) begin
      if (done_a === 1'b1 || tx_a !== 1'b1) ndone++;
      tick();
    end
    total_cnt++;
    if (ndone != 0)
      $display("FAIL rst_mid idle: %0d cycles with done or tx low, want 0", ndone);
    else pass_cnt++;
    test_frame(0, 8'h0F, 1'b0, "post_rst_0f");
  endtask

`ifdef PARITY_TX_ERRINJ_EN
  task automatic test_errinj();
    inject_err = 1'b1;
    test_frame(0, 8'hA5, 1'b1, "errinj_on");
    inject_err = 1'b0;
    test_frame(0, 8'hA5, 1'b0, "errinj_off");
  endtask
`endif

  initial begin
    rst        = 1'b1;
    data_in    = 8'h00;
    inject_err = 1'b0;
    valid_a    = 1'b0;
    valid_b    = 1'b0;
    valid_c    = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_rst_mid();
`ifdef PARITY_TX_ERRINJ_EN
    test_errinj();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
